dma_chan_scheduler: RTL and testbench

- Shares one dma_func_wrapper engine between NUM_CHAN descriptor requesters, e.g. per-tile or per-core CSR descriptor FIFOs.
- Round-robin arbitration across requesters; holds the granted descriptor stable for the engine; sequences the dma_go pulse; waits for engine completion.
- Keeps per-channel done-IRQ counters and a sticky, halting error report.
- Sits between the descriptor FIFOs and dma_func_wrapper inside the DMA AXI wrapper.

---
 rtl/dma_pkg.sv | 23 ++
 rtl/dma_rr_arbiter.sv | 38 +++
 rtl/dma_chan_scheduler.sv | 160 ++++++++++++++++
 tb/tb_dma_chan_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA types and constants.
//   s_dma_desc_t        : descriptor handed to the DMA engine {src_addr, dst_addr, num_bytes}
//   e_dma_sched_state_t : channel scheduler sequencing states
//   DMA_DESC_W          : packed descriptor width
//   SCHED_CHAN_IDX_W    : width of an encoded scheduler channel index
package dma_pkg;

   localparam int DMA_DESC_W       = 96;
   localparam int SCHED_CHAN_IDX_W = 4;

   typedef struct packed {
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
      logic [31:0] num_bytes;
   } s_dma_desc_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } e_dma_sched_state_t;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index for this decision (must be < NUM_CHAN)
//   grant     : one-hot grant, first request at or above ptr, wrapping
//   grant_idx : encoded index of the granted request (0 when nothing granted)
module dma_rr_arbiter #(
   parameter int NUM_CHAN = 4,
   parameter int IDX_W    = 4
) (
   input  logic [NUM_CHAN-1:0] req,
   input  logic [IDX_W-1:0]    ptr,
   output logic [NUM_CHAN-1:0] grant,
   output logic [IDX_W-1:0]    grant_idx
);

   logic found;

   // NOTE: every signal written here gets a default before the loop, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      // Walk offsets i = 0..NUM_CHAN-1 away from ptr; channel j sits at
      // offset i when ptr + i equals j, either directly or after one wrap.
      for (int i = 0; i < NUM_CHAN; i++) begin
         for (int j = 0; j < NUM_CHAN; j++) begin
            if (!found && req[j] &&
                ((int'(ptr) + i == j) || (int'(ptr) + i == j + NUM_CHAN))) begin
               grant[j]  = 1'b1;
               grant_idx = IDX_W'(j);
               found     = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dma_chan_scheduler.sv
// Shares one DMA engine between NUM_CHAN descriptor requesters.
//   req_valid_i/req_desc_i/req_last_i/req_ready_o : per-channel descriptor handshake
//   dma_go_o/dma_desc_o                           : start pulse and held descriptor to engine
//   dma_done_i/dma_error_i                        : engine completion / error pulses
//   irq_clear_i/irq_done_o                        : per-channel saturating done-IRQ counters
//   err_clear_i/irq_error_o/err_chan_o/err_timeout_o : sticky, halting error report
//   busy_o                                        : a descriptor is in flight
module dma_chan_scheduler
   import dma_pkg::*;
#(
   parameter int NUM_CHAN = 4,
   parameter int CNT_W    = 4,
   parameter int TIMEOUT  = 1024
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [NUM_CHAN-1:0]            req_valid_i,
   input  logic [NUM_CHAN*DMA_DESC_W-1:0] req_desc_i,
   input  logic [NUM_CHAN-1:0]            req_last_i,
   output logic [NUM_CHAN-1:0]            req_ready_o,
   output logic                           dma_go_o,
   output logic [DMA_DESC_W-1:0]          dma_desc_o,
   input  logic                           dma_done_i,
   input  logic                           dma_error_i,
   input  logic [NUM_CHAN-1:0]            irq_clear_i,
   input  logic                           err_clear_i,
   output logic [NUM_CHAN-1:0]            irq_done_o,
   output logic                           irq_error_o,
   output logic [SCHED_CHAN_IDX_W-1:0]    err_chan_o,
   output logic                           err_timeout_o,
   output logic                           busy_o
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   // The watchdog counts from 0 in the first WAIT cycle, so the TIMEOUT-th
   // WAIT cycle is the one where it holds TIMEOUT-1.
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   e_dma_sched_state_t            state_q, state_d;
   logic [SCHED_CHAN_IDX_W-1:0]   rr_ptr_q, grant_idx, ch_q;
   logic [NUM_CHAN-1:0]           grant, inc_vec;
   s_dma_desc_t                   desc_q, sel_desc;
   logic                          last_q, sel_last;
   logic [WD_W-1:0]               wd_q;
   logic                          halt, in_wait, handshake, timeout_hit, err_evt, done_ok;
   logic [CNT_W-1:0]              cnt_q [NUM_CHAN];

   dma_rr_arbiter #(
      .NUM_CHAN (NUM_CHAN),
      .IDX_W    (SCHED_CHAN_IDX_W)
   ) u_arb (
      .req       (req_valid_i),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      halt        = irq_error_o;
      in_wait     = (state_q == WAIT);
      handshake   = (state_q == IDLE) && !halt && (grant != '0);
      timeout_hit = (TIMEOUT != 0) && in_wait && (wd_q == WD_LAST);
      // A real completion on the last watchdog cycle beats the timeout.
      err_evt     = in_wait && (dma_error_i || (timeout_hit && !dma_done_i));
      done_ok     = in_wait && dma_done_i && !dma_error_i;
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = '0;
      dma_go_o    = 1'b0;
      busy_o      = (state_q != IDLE);
      unique case (state_q)
         IDLE: begin
            if (handshake) begin
               state_d     = ISSUE;
               req_ready_o = grant;
            end
         end
         ISSUE: begin
            state_d  = WAIT;
            dma_go_o = 1'b1;
         end
         WAIT: begin
            if (dma_done_i || dma_error_i || timeout_hit) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_desc   = '0;
      sel_last   = 1'b0;
      inc_vec    = '0;
      irq_done_o = '0;
      for (int k = 0; k < NUM_CHAN; k++) begin
         if (grant[k]) begin
            sel_desc = req_desc_i[k*DMA_DESC_W +: DMA_DESC_W];
            sel_last = req_last_i[k];
         end
         if (done_ok && last_q && (ch_q == SCHED_CHAN_IDX_W'(k))) inc_vec[k] = 1'b1;
         irq_done_o[k] = (cnt_q[k] != '0);
      end
   end

   assign dma_desc_o = desc_q;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         ch_q          <= '0;
         desc_q        <= '0;
         last_q        <= 1'b0;
         wd_q          <= '0;
         irq_error_o   <= 1'b0;
         err_chan_o    <= '0;
         err_timeout_o <= 1'b0;
      end else begin
         state_q <= state_d;
         if (handshake) begin
            desc_q   <= sel_desc;
            last_q   <= sel_last;
            ch_q     <= grant_idx;
            rr_ptr_q <= (grant_idx == SCHED_CHAN_IDX_W'(NUM_CHAN - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (state_q == ISSUE)  wd_q <= '0;
         else if (in_wait)      wd_q <= wd_q + 1'b1;
         // A new error outranks a simultaneous clear; the channel index is kept
         // after a clear so software can still read where the last fault was.
         if (err_evt) begin
            irq_error_o   <= 1'b1;
            err_chan_o    <= ch_q;
            err_timeout_o <= !dma_error_i;
         end else if (err_clear_i) begin
            irq_error_o   <= 1'b0;
            err_timeout_o <= 1'b0;
         end
      end
   end

   // NOTE: the counter array is reset explicitly because irq_done_o decodes
   // it directly; an unreset array would raise spurious IRQs after power-up.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_CHAN; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CHAN; k++) begin
            if (inc_vec[k] && !irq_clear_i[k] && (cnt_q[k] != CNT_MAX))
               cnt_q[k] <= cnt_q[k] + 1'b1;
            else if (irq_clear_i[k] && !inc_vec[k] && (cnt_q[k] != '0))
               cnt_q[k] <= cnt_q[k] - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dma_chan_scheduler.sv
// Self-checking bench for dma_chan_scheduler (4 channels, 4-bit counters,
// 16-cycle watchdog). Inputs change on the falling edge; outputs are checked
// 1 ns later against a transaction-level model of the scheduler's rules.
module tb_dma_chan_scheduler;

   localparam int N    = 4;
   localparam int CW   = 4;
   localparam int TMO  = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rstn;
   logic [N-1:0]    req_valid, req_last, req_ready, irq_clear, irq_done;
   logic [N*96-1:0] req_desc;
   logic            dma_go, dma_done, dma_error, err_clear, irq_error, err_timeout, busy;
   logic [95:0]     dma_desc;
   logic [3:0]      err_chan;

   dma_chan_scheduler #(.NUM_CHAN(N), .CNT_W(CW), .TIMEOUT(TMO)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .req_valid_i   (req_valid),
      .req_desc_i    (req_desc),
      .req_last_i    (req_last),
      .req_ready_o   (req_ready),
      .dma_go_o      (dma_go),
      .dma_desc_o    (dma_desc),
      .dma_done_i    (dma_done),
      .dma_error_i   (dma_error),
      .irq_clear_i   (irq_clear),
      .err_clear_i   (err_clear),
      .irq_done_o    (irq_done),
      .irq_error_o   (irq_error),
      .err_chan_o    (err_chan),
      .err_timeout_o (err_timeout),
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          m_ptr, m_err_ch;
   int          m_cnt [N];
   bit          m_err, m_tmo, quiet;
   int          cur_ch;
   logic [95:0] cur_desc;
   bit          cur_last;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_err = 0; m_err_ch = 0; m_tmo = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
   endtask

   // First valid channel at or after ptr, wrapping; -1 if none.
   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      for (int i = 0; i < N; i++)
         if (v[(ptr + i) % N]) return (ptr + i) % N;
      return -1;
   endfunction

   // Check one cycle's outputs, then advance the model across the next edge.
   task automatic cyc(input bit in_wait, input bit tmo, input logic [N-1:0] exp_ready,
                      input bit exp_go, input bit exp_busy);
      logic [N-1:0] exp_irq;
      bit err_now, done_ok, inc, clr;
      #1;
      for (int k = 0; k < N; k++) exp_irq[k] = (m_cnt[k] != 0);
      check("ready", req_ready, exp_ready);
      check("go", dma_go, exp_go);
      check("busy", busy, exp_busy);
      if (exp_busy) check("desc", dma_desc, cur_desc);
      check("irq_done", irq_done, exp_irq);
      check("irq_error", irq_error, m_err);
      check("err_chan", err_chan, m_err_ch);
      check("err_timeout", err_timeout, m_tmo);
      err_now = in_wait && (dma_error || tmo);
      done_ok = in_wait && dma_done && !dma_error;
      for (int k = 0; k < N; k++) begin
         inc = done_ok && cur_last && (cur_ch == k);
         clr = irq_clear[k];
         if (inc && !clr && m_cnt[k] < CMAX) m_cnt[k]++;
         else if (clr && !inc && m_cnt[k] > 0) m_cnt[k]--;
      end
      if (err_now) begin
         m_err = 1; m_err_ch = cur_ch; m_tmo = !dma_error;
      end else if (err_clear) begin
         m_err = 0; m_tmo = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle_cyc(output int g);
      logic [N-1:0] er;
      er = '0;
      g  = m_err ? -1 : rr_pick(req_valid, m_ptr);
      if (g >= 0) er[g] = 1'b1;
      cyc(1'b0, 1'b0, er, 1'b0, 1'b0);
      if (g >= 0) begin
         cur_ch   = g;
         cur_desc = req_desc[g*96 +: 96];
         cur_last = req_last[g];
         m_ptr    = (g + 1) % N;
      end
   endtask

   task automatic side(input bit allow_stray);
      dma_done = 0; dma_error = 0; irq_clear = '0; err_clear = 0;
      if (!quiet) begin
         if ($urandom_range(7) == 0) irq_clear = N'($urandom);
         if (m_err ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0)) err_clear = 1;
         if (allow_stray) begin
            dma_done  = ($urandom_range(7) == 0);
            dma_error = ($urandom_range(11) == 0);
         end
      end
   endtask

   task automatic put(input int k, input bit last);
      req_valid[k]         = 1'b1;
      req_desc[k*96 +: 96] = {$urandom, $urandom, $urandom};
      req_last[k]          = last;
   endtask

   task automatic refill(input bit all);
      for (int k = 0; k < N; k++)
         if (!req_valid[k] && (all || $urandom_range(2) == 0)) put(k, 1'($urandom_range(1)));
   endtask

   // One descriptor: idle until granted, issue, then the engine answers in
   // WAIT cycle 'lat'. kind: 0 done, 1 error, 2 done+error, 3 no answer.
   // fill: 0 none, 1 random refill, 2 keep every channel valid.
   task automatic do_txn(input int lat, input int kind, input int fill, input bit clr_resp);
      int g = -1;
      int n = 0;
      while (g < 0) begin
         side(1'b1);
         if (fill != 0) refill(fill == 2);
         idle_cyc(g);
         if (g < 0) begin
            n++;
            if (n > 200) begin
               check("grant_bound", n, 0);
               return;
            end
         end
      end
      req_valid[g] = 1'b0;
      side(1'b1);
      if (fill != 0) refill(fill == 2);
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
      for (int j = 1; j <= lat; j++) begin
         side(1'b0);
         if (j == lat && kind != 3) begin
            dma_done  = (kind != 1);
            dma_error = (kind != 0);
            if (dma_error && !quiet) err_clear = 1'($urandom_range(1));
            if (clr_resp) irq_clear[cur_ch] = 1'b1;
         end
         cyc(1'b1, (kind == 3) && (j == lat), '0, 1'b0, 1'b1);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (req_valid != '0 && n < 50) begin
         do_txn(2, 0, 0, 0);
         n++;
      end
   endtask

   task automatic clear_all();
      int g;
      repeat (CMAX) begin
         side(1'b0);
         irq_clear = '1;
         idle_cyc(g);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL sim_timeout: observed running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int g, r, kind, lat;
      rstn = 0; req_valid = '0; req_last = '0; req_desc = '0;
      dma_done = 0; dma_error = 0; irq_clear = '0; err_clear = 0;
      quiet = 1; model_reset();
      cur_ch = 0; cur_desc = '0; cur_last = 0;
      repeat (2) @(negedge clk);
      rstn = 1;
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Single request on channel 2, then acknowledge its done IRQ.
      req_valid[2] = 1'b1;
      req_desc[2*96 +: 96] = {32'h1000, 32'h2000, 32'd64};
      req_last[2] = 1'b1;
      do_txn(3, 0, 0, 0);
      side(1'b0); idle_cyc(g);
      side(1'b0); irq_clear[2] = 1'b1; idle_cyc(g);
      side(1'b0); idle_cyc(g);

      // All channels continuously valid, done 5 cycles after each go.
      repeat (8) do_txn(5, 0, 2, 0);
      drain();
      clear_all();

      // Channel 1: last = 0, 0, 1.
      for (int i = 0; i < 3; i++) begin
         put(1, i == 2);
         do_txn(4, 0, 0, 0);
      end
      side(1'b0); idle_cyc(g);

      // Error together with done on channel 3; channel 0 waits out the halt.
      put(3, 1'b1);
      do_txn(2, 2, 0, 0);
      put(0, 1'b1);
      repeat (4) begin side(1'b0); idle_cyc(g); end
      side(1'b0); err_clear = 1'b1; idle_cyc(g);
      do_txn(3, 0, 0, 0);

      // Watchdog expiry on channel 2.
      put(2, 1'b1);
      do_txn(TMO, 3, 0, 0);
      side(1'b0); idle_cyc(g);
      side(1'b0); err_clear = 1'b1; idle_cyc(g);

      // Counter edges on channel 0: inc+clear, saturation, clear down past 0.
      clear_all();
      put(0, 1'b1); do_txn(1, 0, 0, 0);
      put(0, 1'b1); do_txn(2, 0, 0, 1);
      repeat (16) begin put(0, 1'b1); do_txn(1, 0, 0, 0); end
      repeat (CMAX + 1) begin side(1'b0); irq_clear[0] = 1'b1; idle_cyc(g); end
      side(1'b0); idle_cyc(g);

      // Randomised traffic.
      quiet = 0;
      repeat (120) begin
         r    = $urandom_range(99);
         kind = (r < 65) ? 0 : (r < 80) ? 1 : (r < 93) ? 2 : 3;
         lat  = (kind == 3) ? TMO : $urandom_range(TMO, 1);
         do_txn(lat, kind, 1, 1'($urandom_range(3) == 0));
      end
      drain();
      side(1'b0); err_clear = 1'b1; idle_cyc(g);

      // Asynchronous reset while waiting on the engine.
      quiet = 1;
      put(1, 1'b1);
      side(1'b0); idle_cyc(g);
      req_valid = '0;
      side(1'b0); cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
      side(1'b0); cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
      #2 rstn = 0;
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_go", dma_go, 0);
      check("rst_desc", dma_desc, 0);
      check("rst_irq_done", irq_done, 0);
      check("rst_irq_error", irq_error, 0);
      check("rst_err_chan", err_chan, 0);
      check("rst_err_timeout", err_timeout, 0);
      check("rst_busy", busy, 0);
      model_reset();
      @(negedge clk);
      rstn = 1;
      side(1'b0); cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
